equiv_stim_checker: RTL and testbench

- Synthesizable successor to the fixed-vector simulation harness used in the equivalence-checking flow.
- Generates a parametrised LFSR stimulus stream and drives it into two design copies: the pre-synthesis "gold" and the post-synthesis "rev".
- Compares their outputs cycle by cycle after a configurable DUT latency and compacts the gold outputs into a MISR signature.
- Reports pass/fail, the first mismatch index and a mismatch count; sits between the stimulus-side concatenated input bus and the two top instances.

---
 rtl/equiv_stim_checker.sv | 200 ++++++++++++++++++++
 tb/tb_equiv_stim_checker.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/equiv_stim_checker.sv
// LFSR stimulus generator and gold/rev output comparator for equivalence runs.
// Drives both design copies, checks outputs after LATENCY cycles and compacts gold into a MISR.
module equiv_stim_checker #(
    parameter int                IN_W         = 68,
    parameter int                OUT_W        = 255,
    parameter int                NUM_VEC      = 20,
    parameter int                LATENCY      = 0,
    parameter logic [IN_W-1:0]   SEED         = IN_W'(1),
    parameter logic [IN_W-1:0]   TAPS         = IN_W'(68'h8_0000_0000_0000_0041),
    parameter int                SIG_W        = 32,
    parameter logic [SIG_W-1:0]  SIG_TAPS     = 32'h8020_0003,
    parameter int                STOP_ON_FAIL = 0,
    localparam int               IDX_W        = $clog2(NUM_VEC + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [IN_W-1:0]   stim_out,
    output logic              stim_valid,
    input  logic [OUT_W-1:0]  y_gold,
    input  logic [OUT_W-1:0]  y_rev,
    output logic              busy,
    output logic              done,
    output logic              mismatch,
    output logic [IDX_W-1:0]  first_idx,
    output logic [IDX_W-1:0]  fail_cnt,
    output logic [SIG_W-1:0]  signature
);

    localparam int NSLICE = (OUT_W + SIG_W - 1) / SIG_W;
    localparam int EXT_W  = NSLICE * SIG_W;
    localparam logic [IN_W-1:0]  SEED_EFF = (SEED == '0) ? IN_W'(1) : SEED;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);
    localparam logic [IDX_W-1:0] MAX_CNT  = IDX_W'(NUM_VEC);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    function automatic logic [IN_W-1:0] lfsr_next(input logic [IN_W-1:0] s);
        return {s[IN_W-2:0], ^(s & TAPS)};
    endfunction

    function automatic logic [SIG_W-1:0] fold(input logic [OUT_W-1:0] y);
        logic [EXT_W-1:0] ext;
        logic [SIG_W-1:0] r;
        ext = EXT_W'(y);
        r   = '0;
        for (int s = 0; s < NSLICE; s++) r ^= ext[s*SIG_W +: SIG_W];
        return r;
    endfunction

    function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s,
                                                   input logic [OUT_W-1:0] y);
        return {s[SIG_W-2:0], ^(s & SIG_TAPS)} ^ fold(y);
    endfunction

    function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] c);
        return (c >= MAX_CNT) ? c : c + 1'b1;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [IN_W-1:0]  stim_q, stim_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             mismatch_q, mismatch_d;
    logic [IDX_W-1:0] first_idx_q, first_idx_d;
    logic [IDX_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [SIG_W-1:0] sig_q, sig_d;

    logic             cap_valid;
    logic [IDX_W-1:0] cap_idx;
    logic             pending;
    logic             mis_now;
    logic             start_go;
    logic             stop_go;

    assign stim_valid = (state_q == S_RUN);
    assign start_go   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign mis_now    = cap_valid && (y_gold != y_rev);
    // Stopping early also throws away vectors still travelling through the delay pipe.
    assign stop_go    = (STOP_ON_FAIL != 0) && mis_now;

    // ---- stage: {valid, idx} delay pipe aligning issued vectors with DUT outputs ----
    if (LATENCY > 0) begin : g_pipe
        logic [LATENCY-1:0] pv_q, pv_d;
        logic [IDX_W-1:0]   pi_q [LATENCY];
        logic [IDX_W-1:0]   pi_d [LATENCY];

        always_comb begin
            pv_d    = '0;
            pi_d[0] = idx_q;
            for (int i = 1; i < LATENCY; i++) pi_d[i] = pi_q[i-1];
            if (!(start_go || stop_go)) begin
                pv_d[0] = stim_valid;
                for (int i = 1; i < LATENCY; i++) pv_d[i] = pv_q[i-1];
            end
        end

        // The oldest entry is consumed on this edge, so only earlier stages keep DRAIN alive.
        always_comb begin
            pending = 1'b0;
            for (int i = 0; i < LATENCY - 1; i++) pending |= pv_q[i];
        end

        always_ff @(posedge clk) begin
            if (rst) pv_q <= '0;
            else     pv_q <= pv_d;
        end

        always_ff @(posedge clk) pi_q <= pi_d;

        assign cap_valid = pv_q[LATENCY-1];
        assign cap_idx   = pi_q[LATENCY-1];
    end else begin : g_comb
        assign cap_valid = stim_valid;
        assign cap_idx   = idx_q;
        assign pending   = 1'b0;
    end

    // ---- stage: compare, compaction and run control ----
    always_comb begin
        state_d     = state_q;
        stim_d      = stim_q;
        idx_d       = idx_q;
        mismatch_d  = mismatch_q;
        first_idx_d = first_idx_q;
        fail_cnt_d  = fail_cnt_q;
        sig_d       = sig_q;

        if (cap_valid) begin
            sig_d = misr_next(sig_q, y_gold);
            if (y_gold != y_rev) begin
                fail_cnt_d = sat_inc(fail_cnt_q);
                if (!mismatch_q) begin
                    mismatch_d  = 1'b1;
                    first_idx_d = cap_idx;
                end
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_go) begin
                    state_d     = S_RUN;
                    stim_d      = SEED_EFF;
                    idx_d       = '0;
                    mismatch_d  = 1'b0;
                    first_idx_d = '0;
                    fail_cnt_d  = '0;
                    sig_d       = '0;
                end
            end
            S_RUN: begin
                // Last vector stays on stim_out while the pipe drains.
                if (idx_q == LAST_IDX) begin
                    state_d = (LATENCY > 0) ? S_DRAIN : S_DONE;
                end else begin
                    stim_d = lfsr_next(stim_q);
                    idx_d  = idx_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (!pending) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (stop_go) state_d = S_DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            stim_q      <= SEED_EFF;
            idx_q       <= '0;
            mismatch_q  <= 1'b0;
            first_idx_q <= '0;
            fail_cnt_q  <= '0;
            sig_q       <= '0;
        end else begin
            state_q     <= state_d;
            stim_q      <= stim_d;
            idx_q       <= idx_d;
            mismatch_q  <= mismatch_d;
            first_idx_q <= first_idx_d;
            fail_cnt_q  <= fail_cnt_d;
            sig_q       <= sig_d;
        end
    end

    assign stim_out  = stim_q;
    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign mismatch  = mismatch_q;
    assign first_idx = first_idx_q;
    assign fail_cnt  = fail_cnt_q;
    assign signature = sig_q;

endmodule

// File: tb/tb_equiv_stim_checker.sv
// Bench for equiv_stim_checker: three configurations (combinational, 3-stage, 2-stage stop-on-fail)
// driven from a run table plus hand-written reset and restart sequences.
module tb_equiv_stim_checker;

    localparam int          OW    = 40;
    localparam logic [31:0] STAPS = 32'h8020_0003;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic start_a [3];
    logic rst_a   [3];
    logic [255:0] hitv0 = '0, hitv1 = '0, hitv2 = '0;

    logic [7:0]    stim0, stim1, stim2;
    logic          sv0, sv1, sv2, busy0, busy1, busy2, done0, done1, done2, mis0, mis1, mis2;
    logic [OW-1:0] yg0, yr0, yg1, yr1, yg2, yr2;
    logic [2:0]    fidx0, fcnt0;
    logic [4:0]    fidx1, fcnt1, fidx2, fcnt2;
    logic [31:0]   sig0, sig1, sig2;

    logic [7:0] exp_vec [20];
    int checks = 0;
    int errors = 0;

    function automatic logic [7:0] lfsr_m(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [OW-1:0] gold_of(input logic [7:0] v);
        return {v, 16'h0, v, 8'h0};
    endfunction

    function automatic logic [31:0] misr_m(input logic [31:0] s, input logic [OW-1:0] y);
        logic [31:0] f;
        f = '0;
        for (int b = 0; b < OW; b++) f[b % 32] = f[b % 32] ^ y[b];
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ f;
    endfunction

    // DUT copy models: gold is a fixed function of the vector, rev flips bit 0 on chosen vectors.
    logic f0, f1, f2;
    assign f0  = sv0 & hitv0[stim0];
    assign f1  = sv1 & hitv1[stim1];
    assign f2  = sv2 & hitv2[stim2];
    assign yg0 = gold_of(stim0);
    assign yr0 = yg0 ^ OW'(f0);

    logic [7:0] d1s [3];
    logic       d1f [3];
    logic [7:0] d2s [2];
    logic       d2f [2];
    always @(posedge clk) begin
        d1s[0] <= stim1; d1f[0] <= f1;
        d1s[1] <= d1s[0]; d1f[1] <= d1f[0];
        d1s[2] <= d1s[1]; d1f[2] <= d1f[1];
        d2s[0] <= stim2; d2f[0] <= f2;
        d2s[1] <= d2s[0]; d2f[1] <= d2f[0];
    end
    assign yg1 = gold_of(d1s[2]);
    assign yr1 = yg1 ^ OW'(d1f[2]);
    assign yg2 = gold_of(d2s[1]);
    assign yr2 = yg2 ^ OW'(d2f[1]);

    equiv_stim_checker #(.IN_W(8), .OUT_W(OW), .NUM_VEC(4), .LATENCY(0), .SEED(8'd1),
        .TAPS(8'hB8), .SIG_W(32), .SIG_TAPS(STAPS), .STOP_ON_FAIL(0)) u0 (
        .clk(clk), .rst(rst_a[0]), .start(start_a[0]), .stim_out(stim0), .stim_valid(sv0),
        .y_gold(yg0), .y_rev(yr0), .busy(busy0), .done(done0), .mismatch(mis0),
        .first_idx(fidx0), .fail_cnt(fcnt0), .signature(sig0));

    equiv_stim_checker #(.IN_W(8), .OUT_W(OW), .NUM_VEC(20), .LATENCY(3), .SEED(8'd1),
        .TAPS(8'hB8), .SIG_W(32), .SIG_TAPS(STAPS), .STOP_ON_FAIL(0)) u1 (
        .clk(clk), .rst(rst_a[1]), .start(start_a[1]), .stim_out(stim1), .stim_valid(sv1),
        .y_gold(yg1), .y_rev(yr1), .busy(busy1), .done(done1), .mismatch(mis1),
        .first_idx(fidx1), .fail_cnt(fcnt1), .signature(sig1));

    equiv_stim_checker #(.IN_W(8), .OUT_W(OW), .NUM_VEC(20), .LATENCY(2), .SEED(8'd0),
        .TAPS(8'hB8), .SIG_W(32), .SIG_TAPS(STAPS), .STOP_ON_FAIL(1)) u2 (
        .clk(clk), .rst(rst_a[2]), .start(start_a[2]), .stim_out(stim2), .stim_valid(sv2),
        .y_gold(yg2), .y_rev(yr2), .busy(busy2), .done(done2), .mismatch(mis2),
        .first_idx(fidx2), .fail_cnt(fcnt2), .signature(sig2));

    logic        sv_a [3], busy_a [3], done_a [3], mis_a [3];
    logic [7:0]  stim_a [3];
    logic [31:0] sig_a [3];
    int          fidx_a [3], fcnt_a [3];
    assign sv_a[0] = sv0;     assign sv_a[1] = sv1;     assign sv_a[2] = sv2;
    assign busy_a[0] = busy0; assign busy_a[1] = busy1; assign busy_a[2] = busy2;
    assign done_a[0] = done0; assign done_a[1] = done1; assign done_a[2] = done2;
    assign mis_a[0] = mis0;   assign mis_a[1] = mis1;   assign mis_a[2] = mis2;
    assign stim_a[0] = stim0; assign stim_a[1] = stim1; assign stim_a[2] = stim2;
    assign sig_a[0] = sig0;   assign sig_a[1] = sig1;   assign sig_a[2] = sig2;
    assign fidx_a[0] = int'(fidx0); assign fidx_a[1] = int'(fidx1); assign fidx_a[2] = int'(fidx2);
    assign fcnt_a[0] = int'(fcnt0); assign fcnt_a[1] = int'(fcnt1); assign fcnt_a[2] = int'(fcnt2);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_hit(input int inst, input int unsigned mask);
        logic [255:0] h;
        h = '0;
        for (int k = 0; k < 20; k++) if (mask[k]) h[exp_vec[k]] = 1'b1;
        case (inst)
            0:       hitv0 = h;
            1:       hitv1 = h;
            default: hitv2 = h;
        endcase
    endtask

    task automatic check_reset_state(input int inst);
        chk("rst_stim", int'(stim_a[inst]), 1);
        chk("rst_valid", int'(sv_a[inst]), 0);
        chk("rst_busy", int'(busy_a[inst]), 0);
        chk("rst_done", int'(done_a[inst]), 0);
        chk("rst_mismatch", int'(mis_a[inst]), 0);
        chk("rst_first_idx", fidx_a[inst], 0);
        chk("rst_fail_cnt", fcnt_a[inst], 0);
        chk("rst_signature", int'(sig_a[inst]), 0);
    endtask

    task automatic run_check(input int inst, input int unsigned mask, input bit exp_mis,
                             input int exp_first, input int exp_cnt, input int exp_done,
                             input int ncmp, input int nv);
        logic [7:0]  q [$];
        logic [7:0]  e;
        logic [31:0] es;
        int          n_issue;
        int          done_at;
        set_hit(inst, mask);
        n_issue = (exp_done - 1 < nv) ? exp_done - 1 : nv;
        for (int k = 0; k < n_issue; k++) q.push_back(exp_vec[k]);
        es = '0;
        for (int k = 0; k < ncmp; k++) es = misr_m(es, gold_of(exp_vec[k]));
        @(negedge clk) start_a[inst] = 1'b1;
        @(negedge clk) start_a[inst] = 1'b0;
        done_at = -1;
        for (int cyc = 1; cyc <= nv + 12; cyc++) begin
            if (cyc == 1) begin
                chk("start_clears_mismatch", int'(mis_a[inst]), 0);
                chk("start_clears_fail_cnt", fcnt_a[inst], 0);
            end
            chk("busy", int'(busy_a[inst]), int'(cyc < exp_done));
            chk("stim_valid", int'(sv_a[inst]), int'(cyc <= n_issue));
            if (sv_a[inst]) begin
                if (q.size() == 0) chk("extra_vector", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("stim_out", int'(stim_a[inst]), int'(e));
                end
            end
            if (done_a[inst]) begin
                done_at = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("done_cycle", done_at, exp_done);
        chk("vectors_missing", q.size(), 0);
        chk("mismatch", int'(mis_a[inst]), int'(exp_mis));
        chk("first_idx", fidx_a[inst], exp_first);
        chk("fail_cnt", fcnt_a[inst], exp_cnt);
        chk("signature", int'(sig_a[inst]), int'(es));
        @(negedge clk);
        chk("done_held", int'(done_a[inst]), 1);
        chk("fail_cnt_held", fcnt_a[inst], exp_cnt);
    endtask

    typedef struct {
        int          inst;
        int unsigned mask;
        bit          mis;
        int          first;
        int          cnt;
        int          done_cyc;
        int          ncmp;
        int          nv;
    } run_t;

    run_t tbl [7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            start_a[i] = 1'b0;
            rst_a[i]   = 1'b1;
        end
        exp_vec[0] = 8'h01;
        for (int k = 1; k < 20; k++) exp_vec[k] = lfsr_m(exp_vec[k-1]);

        tbl[0] = '{0, 32'h0,                          1'b0, 0, 0, 5,  4,  4};
        tbl[1] = '{0, 32'h4,                          1'b1, 2, 1, 5,  4,  4};
        tbl[2] = '{0, 32'hF,                          1'b1, 0, 4, 5,  4,  4};
        tbl[3] = '{1, 32'h0,                          1'b0, 0, 0, 24, 20, 20};
        tbl[4] = '{1, (32'h1 << 3) | (32'h1 << 7) | (32'h1 << 19), 1'b1, 3, 3, 24, 20, 20};
        tbl[5] = '{2, (32'h1 << 5) | (32'h1 << 6),    1'b1, 5, 1, 9,  6,  20};
        tbl[6] = '{2, 32'h0,                          1'b0, 0, 0, 23, 20, 20};

        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) check_reset_state(i);
        for (int i = 0; i < 3; i++) rst_a[i] = 1'b0;

        for (int t = 0; t < 7; t++)
            run_check(tbl[t].inst, tbl[t].mask, tbl[t].mis, tbl[t].first, tbl[t].cnt,
                      tbl[t].done_cyc, tbl[t].ncmp, tbl[t].nv);

        // Reset in the middle of a run, then a clean run must reproduce sequence and signature.
        set_hit(1, 32'h4);
        @(negedge clk) start_a[1] = 1'b1;
        @(negedge clk) start_a[1] = 1'b0;
        repeat (9) @(negedge clk);
        chk("midrun_busy", int'(busy_a[1]), 1);
        chk("midrun_mismatch", int'(mis_a[1]), 1);
        rst_a[1] = 1'b1;
        @(negedge clk);
        check_reset_state(1);
        rst_a[1] = 1'b0;
        run_check(1, 32'h0, 1'b0, 0, 0, 24, 20, 20);

        // start held through RUN is ignored; start in DONE restarts with cleared results.
        set_hit(0, 32'h4);
        @(negedge clk) start_a[0] = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("held_start_stim", int'(stim_a[0]), int'(exp_vec[c-1]));
            chk("held_start_valid", int'(sv_a[0]), 1);
        end
        @(negedge clk) start_a[0] = 1'b0;
        chk("held_start_done", int'(done_a[0]), 1);
        chk("held_start_mismatch", int'(mis_a[0]), 1);
        chk("held_start_first_idx", fidx_a[0], 2);
        run_check(0, 32'h0, 1'b0, 0, 0, 5, 4, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
